// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter and its entry queue.
package wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Writes to the hardwired zero register are acknowledged but never stored.
  function automatic logic is_real_reg(input logic [ADDR_W-1:0] add);
    return add != ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of register writes: up to two pushes (a before b) and one pop per cycle.
// The caller guarantees pushes never exceed free space and pops only happen when non-empty.
module wb_fifo
  import wb_pkg::wb_entry_t;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_push_a,
  input  wb_entry_t                 i_entry_a,
  input  logic                      i_push_b,
  input  wb_entry_t                 i_entry_b,
  input  logic                      i_pop,
  output wb_entry_t                 o_head,
  output logic [$clog2(DEPTH):0]    o_count,
  output wb_entry_t [DEPTH-1:0]     o_entries,
  output logic [DEPTH-1:0]          o_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_valid_next;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_wr_ptr1;
  wb_entry_t        w_slot0;
  logic             w_wr0;
  logic             w_wr1;
  logic [1:0]       w_n_push;

  // A lone push always lands in the first free slot, whichever producer it came from.
  assign w_wr0     = i_push_a | i_push_b;
  assign w_wr1     = i_push_a & i_push_b;
  assign w_slot0   = i_push_a ? i_entry_a : i_entry_b;
  assign w_wr_ptr1 = r_wr_ptr + 1'b1;
  assign w_n_push  = {1'b0, i_push_a} + {1'b0, i_push_b};

  always_ff @(posedge clock) begin
    if (w_wr0) r_mem[r_wr_ptr]  <= w_slot0;
    if (w_wr1) r_mem[w_wr_ptr1] <= i_entry_b;
  end

  always_comb begin
    w_valid_next = r_valid;
    if (i_pop) w_valid_next[r_rd_ptr]  = 1'b0;
    if (w_wr0) w_valid_next[r_wr_ptr]  = 1'b1;
    if (w_wr1) w_valid_next[w_wr_ptr1] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_n_push);
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= r_count + CW'(w_n_push) - CW'(i_pop);
      r_valid  <= w_valid_next;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_valid = r_valid;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entries
    assign o_entries[gi] = r_mem[gi];
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges load-path and ALU-path register writes into one registered write port,
// and flags reads that would race a pending write.
module wb_arbiter
  import wb_pkg::ZERO_REG, wb_pkg::wb_entry_t, wb_pkg::is_real_reg;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_W-1:0]          mem_add,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_add,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       write_en,
  output logic [ADDR_W-1:0]          write_add,
  output logic [DATA_W-1:0]          write_data,
  input  logic [ADDR_W-1:0]          chk_add1,
  input  logic [ADDR_W-1:0]          chk_add2,
  output logic                       hazard_1,
  output logic                       hazard_2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_free;
  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]      w_valid;
  wb_entry_t             w_mem_entry;
  wb_entry_t             w_alu_entry;
  logic                  w_mem_real;
  logic                  w_mem_push;
  logic                  w_alu_push;
  logic                  w_pop;
  logic [DEPTH-1:0]      w_match1;
  logic [DEPTH-1:0]      w_match2;
  logic                  r_write_en;
  logic [ADDR_W-1:0]     r_write_add;
  logic [DATA_W-1:0]     r_write_data;

  // Free space ignores this cycle's pop, so ready never depends on the drain.
  assign w_free     = DEPTH_C - w_count;
  assign w_mem_real = mem_valid && is_real_reg(mem_add);
  assign mem_ready  = (w_free != '0);
  assign alu_ready  = (w_free >= CW'(2)) || ((w_free == CW'(1)) && !w_mem_real);

  assign w_mem_push  = w_mem_real && mem_ready;
  assign w_alu_push  = alu_valid && alu_ready && is_real_reg(alu_add);
  assign w_pop       = (w_count != '0);
  assign w_mem_entry = {mem_add, mem_data};
  assign w_alu_entry = {alu_add, alu_data};

  // The load belongs to the older instruction, so it takes the first slot.
  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_push_a  (w_mem_push),
    .i_entry_a (w_mem_entry),
    .i_push_b  (w_alu_push),
    .i_entry_b (w_alu_entry),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_write_en   <= 1'b0;
      r_write_add  <= '0;
      r_write_data <= '0;
    end else begin
      r_write_en <= w_pop;
      if (w_pop) begin
        r_write_add  <= w_head.add;
        r_write_data <= w_head.data;
      end
    end
  end

  assign write_en   = r_write_en;
  assign write_add  = r_write_add;
  assign write_data = r_write_data;
  assign count      = w_count;
  assign full       = (w_count == DEPTH_C);
  assign empty      = (w_count == '0);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
    assign w_match1[gi] = w_valid[gi] && (w_entries[gi].add == chk_add1);
    assign w_match2[gi] = w_valid[gi] && (w_entries[gi].add == chk_add2);
  end

  // The write in the output register still counts: the file commits it only at the next edge.
  assign hazard_1 = is_real_reg(chk_add1) &&
                    ((|w_match1) || (r_write_en && (r_write_add == chk_add1)));
  assign hazard_2 = is_real_reg(chk_add2) &&
                    ((|w_match2) || (r_write_en && (r_write_add == chk_add2)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomised stimulus for wb_arbiter with a queue-based scoreboard
// of expected register-file writes.
module tb_wb_arbiter;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              mem_valid, mem_ready, alu_valid, alu_ready;
  logic [ADDR_W-1:0] mem_add, alu_add, write_add, chk_add1, chk_add2;
  logic [DATA_W-1:0] mem_data, alu_data, write_data;
  logic              write_en, hazard_1, hazard_2, full, empty;
  logic [CW-1:0]     count;

  wb_arbiter #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_add   (mem_add),
    .mem_data  (mem_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_add   (alu_add),
    .alu_data  (alu_data),
    .write_en  (write_en),
    .write_add (write_add),
    .write_data(write_data),
    .chk_add1  (chk_add1),
    .chk_add2  (chk_add2),
    .hazard_1  (hazard_1),
    .hazard_2  (hazard_2),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  bit                last_we;
  logic [ADDR_W-1:0] last_add;
  logic [DATA_W-1:0] last_data;
  int                errors = 0;
  int                checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hz_model(input logic [ADDR_W-1:0] a);
    if (a == 5'd31) return 1'b0;
    if (last_we && last_add == a) return 1'b1;
    foreach (sb[i]) if (sb[i].add == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                       input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad);
    mem_valid = mv; mem_add = ma; mem_data = md;
    alu_valid = av; alu_add = aa; alu_data = ad;
  endtask

  // One clock: check combinational/registered state, record accepts, then check the drain.
  task automatic cycle();
    int   pre;
    int   free;
    bit   exp_we;
    exp_t e;
    #1;
    pre  = sb.size();
    free = DEPTH - pre;
    chk("mem_ready", mem_ready, free >= 1);
    chk("alu_ready", alu_ready, (free >= 2) || (free == 1 && !(mem_valid && mem_add != 5'd31)));
    chk("hazard_1", hazard_1, hz_model(chk_add1));
    chk("hazard_2", hazard_2, hz_model(chk_add2));
    chk("count", count, pre);
    chk("full", full, pre == DEPTH);
    chk("empty", empty, pre == 0);
    exp_we = (pre != 0);
    if (mem_valid && mem_ready && mem_add != 5'd31) sb.push_back({mem_add, mem_data});
    if (alu_valid && alu_ready && alu_add != 5'd31) sb.push_back({alu_add, alu_data});
    @(posedge clock);
    #1;
    chk("write_en", write_en, exp_we);
    if (exp_we) begin
      e = sb.pop_front();
      last_add  = e.add;
      last_data = e.data;
      $display("write add=%0d data=%0h", write_add, write_data);
    end
    chk("write_add", write_add, last_add);
    chk("write_data", write_data, last_data);
    last_we = exp_we;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
    last_we = 1'b0; last_add = '0; last_data = '0;
    chk("rst_count", count, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_write_add", write_add, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_hazard_1", hazard_1, 0);
    chk("rst_hazard_2", hazard_2, 0);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);
    @(negedge clock);
  endtask

  initial begin
    chk_add1 = '0; chk_add2 = '0;
    drive(0, 0, 0, 0, 0, 0);
    do_reset();

    // Single ALU write, hazard tracked until write_en falls
    chk_add1 = 5; chk_add2 = 6;
    drive(0, 0, 0, 1, 5, 64'h1234); cycle();
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    // Both producers to x3 in one cycle: load first, ALU value wins
    chk_add1 = 3;
    drive(1, 3, 64'hAA, 1, 3, 64'hBB); cycle();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    chk("x3_final", write_data, 64'hBB);

    // Continuous pressure from both producers with distinct adds
    chk_add1 = 4; chk_add2 = 9;
    for (int i = 0; i < 8; i++) begin
      drive(1, ADDR_W'(2 * i), 64'h100 + 64'(i), 1, ADDR_W'(2 * i + 1), 64'h200 + 64'(i));
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (5) cycle();

    // Zero-register requests: acked, never queued or written
    chk_add1 = 31; chk_add2 = 31;
    drive(0, 0, 0, 1, 31, 64'hFFFF); cycle();
    drive(1, 31, 64'hDEAD, 1, 31, 64'hBEEF); cycle();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Reset with entries queued and a write in flight
    chk_add1 = 7; chk_add2 = 8;
    drive(1, 7, 64'h70, 1, 8, 64'h80); cycle();
    drive(0, 0, 0, 1, 9, 64'h90); cycle();
    do_reset();
    repeat (4) cycle();

    // Random mixed rates across several pointer wraps
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 1), ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom},
            $urandom_range(0, 1), ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom});
      chk_add1 = ADDR_W'($urandom_range(0, 31));
      chk_add2 = ADDR_W'($urandom_range(0, 31));
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) cycle();
    #1;
    chk("drained_empty", empty, 1);
    chk("drained_no_write", write_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
